// File: rtl/cordic_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_ctrl_pkg : shared types and defaults for the CORDIC sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    MODE_ROTATION  = 1'b0,
    MODE_VECTORING = 1'b1
  } mode_e;

  localparam int DefaultIterations = 16;

endpackage
`default_nettype wire

// File: rtl/cordic_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_ctrl_if : host/datapath handshake bundle of the CORDIC sequencer
// Optional abort line present when CORDIC_CTRL_ABORT_EN is defined.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface cordic_ctrl_if #(
  parameter int IterWidth = 4
);
  logic                 start_valid_i;
  logic                 start_ready_o;
  logic                 mode_i;
  logic                 mode_o;
  logic                 load_o;
  logic                 iter_en_o;
  logic [IterWidth-1:0] iter_idx_o;
  logic                 busy_o;
  logic                 done_valid_o;
  logic                 done_ready_i;
`ifdef CORDIC_CTRL_ABORT_EN
  logic                 abort_i;
`endif

  modport master (
`ifdef CORDIC_CTRL_ABORT_EN
    output abort_i,
`endif
    output start_valid_i, mode_i, done_ready_i,
    input  start_ready_o, mode_o, load_o, iter_en_o, iter_idx_o, busy_o,
           done_valid_o
  );

  modport slave (
`ifdef CORDIC_CTRL_ABORT_EN
    input  abort_i,
`endif
    input  start_valid_i, mode_i, done_ready_i,
    output start_ready_o, mode_o, load_o, iter_en_o, iter_idx_o, busy_o,
           done_valid_o
  );

endinterface
`default_nettype wire

// File: rtl/cordic_iter_cnt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_iter_cnt : enable-gated iteration counter, wraps at LastValue
// Revision: 1.0
// ----------------------------------------------------------------------------
module cordic_iter_cnt #(
  parameter int               Width     = 4,
  parameter logic [Width-1:0] LastValue = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] idx_o,
  output logic             last_o
);

  logic [Width-1:0] idx_q;
  logic [Width-1:0] idx_d;

  assign last_o = (idx_q == LastValue);
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i) begin
      idx_d = last_o ? '0 : idx_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cordic_ctrl : IDLE/LOAD/ITER/DONE sequencer for the iterative CORDIC stage
// Optional abort path enabled by CORDIC_CTRL_ABORT_EN.  Revision: 1.0
// ----------------------------------------------------------------------------
module cordic_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int Iterations = DefaultIterations,
  parameter int IterWidth  = (Iterations > 2) ? $clog2(Iterations) : 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  cordic_ctrl_if.slave   bus
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic                 cnt_en;
  logic                 cnt_clr;
  logic                 cnt_last;
  logic [IterWidth-1:0] cnt_idx;

  cordic_iter_cnt #(
    .Width     (IterWidth),
    .LastValue (IterWidth'(Iterations - 1))
  ) u_iter_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (cnt_en),
    .clr_i  (cnt_clr),
    .idx_o  (cnt_idx),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_en  = 1'b0;
    // Index is held at zero everywhere except while iterating.
    cnt_clr = (state_q != ITER);
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid_i) begin
          mode_d  = mode_e'(bus.mode_i);
          state_d = LOAD;
        end
      end
      LOAD: state_d = ITER;
      ITER: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.done_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef CORDIC_CTRL_ABORT_EN
    if (bus.abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mode_q  <= MODE_ROTATION;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.start_ready_o = (state_q == IDLE);
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.load_o        = (state_q == LOAD);
  assign bus.iter_en_o     = (state_q == ITER);
  assign bus.done_valid_o  = (state_q == DONE);
  assign bus.iter_idx_o    = cnt_idx;
  assign bus.mode_o        = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cordic_ctrl : directed + random stimulus against a cycles-since-accept
// reference model.  Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cordic_ctrl;
  import cordic_ctrl_pkg::*;

  localparam int N = 16;
  localparam int W = 4;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  cordic_ctrl_if #(.IterWidth(W)) bus ();

  cordic_ctrl #(.Iterations(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int n_load   = 0;
  int n_iter   = 0;

  // Reference model: an operation is "active" from accept; m_k counts cycles
  // since the accept edge (1 = load, 2..N+1 = iterations, >= N+2 = done).
  bit m_active = 1'b0;
  int m_k      = 0;
  bit m_mode   = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
  bit abort_req = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ld, it, dn;
    int idx;
    ld  = m_active && (m_k == 1);
    it  = m_active && (m_k >= 2) && (m_k <= N + 1);
    dn  = m_active && (m_k >= N + 2);
    idx = it ? (m_k - 2) : 0;
    chk("start_ready", 32'(bus.start_ready_o), 32'(!m_active));
    chk("busy",        32'(bus.busy_o),        32'(m_active));
    chk("load",        32'(bus.load_o),        32'(ld));
    chk("iter_en",     32'(bus.iter_en_o),     32'(it));
    chk("iter_idx",    32'(bus.iter_idx_o),    32'(idx));
    chk("done_valid",  32'(bus.done_valid_o),  32'(dn));
    chk("mode",        32'(bus.mode_o),        32'(m_mode));
    if (bus.load_o === 1'b1)    n_load++;
    if (bus.iter_en_o === 1'b1) n_iter++;
  endtask

  task automatic cycle(input bit sv, input bit md, input bit dr);
    bus.start_valid_i = sv;
    bus.mode_i        = md;
    bus.done_ready_i  = dr;
`ifdef CORDIC_CTRL_ABORT_EN
    bus.abort_i       = abort_req;
`endif
    @(posedge clk);
    if (!rst_ni) begin
      m_active = 1'b0;
      m_mode   = 1'b0;
    end
`ifdef CORDIC_CTRL_ABORT_EN
    else if (m_active && abort_req) begin
      m_active = 1'b0;
    end
`endif
    else if (m_active) begin
      if (m_k >= N + 2 && dr) m_active = 1'b0;
      else                    m_k++;
    end else if (sv) begin
      m_active = 1'b1;
      m_k      = 1;
      m_mode   = md;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus.start_valid_i = 1'b0;
    bus.mode_i        = 1'b0;
    bus.done_ready_i  = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    bus.abort_i       = 1'b0;
`endif

    // Reset for three cycles, then ten idle cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    rst_ni = 1'b1;
    repeat (10) cycle(1'b0, 1'b0, 1'b0);

    // Single rotation operation, immediate done handshake.
    cycle(1'b1, 1'b0, 1'b0);
    repeat (N + 1) cycle(1'b0, 1'b0, 1'b0);
    chk("done_at_T+18", 32'(bus.done_valid_o), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("ready_at_D+1", 32'(bus.start_ready_o), 32'd1);

    // Vectoring operation with backpressure; stray start pulses ignored.
    cycle(1'b1, 1'b1, 1'b0);
    repeat (N + 1) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    repeat (5) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-to-back: continuous start request, consumer always ready.
    n_load = 0;
    n_iter = 0;
    repeat (3 * (N + 3)) cycle(1'b1, 1'b0, 1'b1);
    chk("b2b_loads", 32'(n_load), 32'd3);
    chk("b2b_iters", 32'(n_iter), 32'(3 * N));

    // Asynchronous reset in the middle of iteration 7.
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && !(m_active && m_k == 9); i++) cycle(1'b0, 1'b0, 1'b0);
    chk("reach_idx7", 32'(bus.iter_idx_o), 32'd7);
    #1 rst_ni = 1'b0;
    #1;
    m_active = 1'b0;
    m_mode   = 1'b0;
    check_all();
    @(negedge clk);
    check_all();
    rst_ni = 1'b1;
    cycle(1'b1, 1'b1, 1'b1);
    repeat (N + 3) cycle(1'b0, 1'b0, 1'b1);

`ifdef CORDIC_CTRL_ABORT_EN
    // Abort at iteration 5, then abort together with a start in IDLE.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !(m_active && m_k == 7); i++) cycle(1'b0, 1'b0, 1'b0);
    chk("reach_idx5", 32'(bus.iter_idx_o), 32'd5);
    abort_req = 1'b1;
    cycle(1'b0, 1'b0, 1'b1);
    chk("abort_idle", 32'(bus.busy_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("abort_idle_accept", 32'(bus.load_o), 32'd1);
    abort_req = 1'b0;
    repeat (N + 3) cycle(1'b0, 1'b0, 1'b1);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef CORDIC_CTRL_ABORT_EN
      abort_req = ($urandom_range(0, 15) == 0);
`endif
      cycle(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
